dispatch_issue: RTL

In-order dual-issue dispatch stage that drains the decode-side instruction FIFO. Each cycle it inspects the two head entries, checks register hazards against a busy-register scoreboard and lane constraints, and issues 0, 1 or 2 instructions into registered execute-lane outputs. It then pops exactly the issued count from the FIFO through `invalid_en`.

---
 rtl/dispatch_issue_pkg.sv | 50 +++++
 rtl/issue_scoreboard.sv | 45 ++++
 rtl/dispatch_issue.sv | 112 +++++++++++
 3 files changed

// File: rtl/dispatch_issue_pkg.sv
// Shared packet layout, register-file sizing and pop encoding for the dispatch stage.
`ifndef DECODE_DATA_WIDTH
`define DECODE_DATA_WIDTH 32
`endif

package dispatch_issue_pkg;

  localparam int unsigned DecodeDataW = `DECODE_DATA_WIDTH;
  localparam int unsigned NRegDefault = 32;
  localparam int unsigned RegAddrW    = 5;

  localparam int unsigned RjLsb      = 0;
  localparam int unsigned RkLsb      = 5;
  localparam int unsigned RdLsb      = 10;
  localparam int unsigned RdWeBit    = 15;
  localparam int unsigned Src1UseBit = 16;
  localparam int unsigned Src2UseBit = 17;
  localparam int unsigned IsLsuBit   = 18;
  localparam int unsigned IsBrBit    = 19;
  localparam int unsigned PktW       = 20;

  localparam logic [1:0] PopNone = 2'b00;
  localparam logic [1:0] PopOne  = 2'b01;
  localparam logic [1:0] PopTwo  = 2'b11;

  typedef struct packed {
    logic [RegAddrW-1:0] rj;
    logic [RegAddrW-1:0] rk;
    logic [RegAddrW-1:0] rd;
    logic                rd_we;
    logic                src1_use;
    logic                src2_use;
    logic                is_lsu;
    logic                is_br;
  } pkt_t;

  function automatic pkt_t unpack_pkt(input logic [PktW-1:0] d);
    pkt_t p;
    p.rj       = d[RjLsb +: RegAddrW];
    p.rk       = d[RkLsb +: RegAddrW];
    p.rd       = d[RdLsb +: RegAddrW];
    p.rd_we    = d[RdWeBit];
    p.src1_use = d[Src1UseBit];
    p.src2_use = d[Src2UseBit];
    p.is_lsu   = d[IsLsuBit];
    p.is_br    = d[IsBrBit];
    return p;
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Busy-register scoreboard: 4 source-ready queries with writeback bypass, 2 sets, 2 clears.
module issue_scoreboard import dispatch_issue_pkg::*; #(
  parameter int unsigned NREG = NRegDefault
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [3:0][RegAddrW-1:0] q_addr_i,
  output logic [3:0]               q_ready_o,
  input  logic [1:0]               set_en_i,
  input  logic [1:0][RegAddrW-1:0] set_addr_i,
  input  logic [1:0]               wb_en_i,
  input  logic [1:0][RegAddrW-1:0] wb_addr_i
);

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    q_ready_o = '0;
    for (int i = 0; i < 4; i++) begin
      q_ready_o[i] = (q_addr_i[i] == '0) || !busy_q[q_addr_i[i]] ||
                     (wb_en_i[0] && (wb_addr_i[0] == q_addr_i[i])) ||
                     (wb_en_i[1] && (wb_addr_i[1] == q_addr_i[i]));
    end
  end

  // Clears first so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < 2; i++) begin
      if (wb_en_i[i]) busy_d[wb_addr_i[i]] = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (set_en_i[i]) busy_d[set_addr_i[i]] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (flush_i) busy_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

endmodule

// File: rtl/dispatch_issue.sv
// In-order dual-issue dispatch: hazard pairing and registered lane outputs.
// Define DUAL_ISSUE_EN to enable lane1; otherwise only single issue is built.
module dispatch_issue import dispatch_issue_pkg::*; #(
  parameter int unsigned DATA_W = DecodeDataW,
  parameter int unsigned NREG   = NRegDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] fifo_data1,
  input  logic [DATA_W-1:0] fifo_data2,
  input  logic              fifo_empty,
  output logic [1:0]        invalid_en,
  input  logic              exe_ready,
  output logic [1:0]        issue_valid,
  output logic [DATA_W-1:0] issue_data1,
  output logic [DATA_W-1:0] issue_data2,
  input  logic [1:0]        wb_en,
  input  logic [4:0]        wb_addr1,
  input  logic [4:0]        wb_addr2
);

  pkt_t                s1;
  logic [3:0]          q_ready;
  logic [RegAddrW-1:0] s2_rj, s2_rk, set_addr2;
  logic                s1_src_ok, s1_writes, slot1_issue, slot2_issue, set2, valid1;
  logic                valid0_q;
  logic [DATA_W-1:0]   data1_q;

  assign s1          = unpack_pkt(fifo_data1[PktW-1:0]);
  assign s1_src_ok   = (!s1.src1_use || q_ready[0]) && (!s1.src2_use || q_ready[1]);
  assign s1_writes   = s1.rd_we && (s1.rd != '0);
  assign slot1_issue = !rst && !fifo_empty && exe_ready && !flush && s1_src_ok;

  issue_scoreboard #(
    .NREG(NREG)
  ) u_sb (
    .clk_i     (clk),
    .rst_i     (rst),
    .flush_i   (flush),
    .q_addr_i  ({s2_rk, s2_rj, s1.rk, s1.rj}),
    .q_ready_o (q_ready),
    .set_en_i  ({set2, slot1_issue && s1_writes}),
    .set_addr_i({set_addr2, s1.rd}),
    .wb_en_i   (wb_en),
    .wb_addr_i ({wb_addr2, wb_addr1})
  );

`ifdef DUAL_ISSUE_EN
  pkt_t              s2;
  logic              s2_src_ok, raw, waw, valid1_q;
  logic [DATA_W-1:0] data2_q;
  logic              unused_s2_br;

  assign s2           = unpack_pkt(fifo_data2[PktW-1:0]);
  assign s2_rj        = s2.rj;
  assign s2_rk        = s2.rk;
  assign unused_s2_br = s2.is_br;
  assign s2_src_ok    = (!s2.src1_use || q_ready[2]) && (!s2.src2_use || q_ready[3]);
  assign raw          = s1_writes && ((s2.src1_use && (s2.rj == s1.rd)) ||
                                      (s2.src2_use && (s2.rk == s1.rd)));
  assign waw          = s1_writes && s2.rd_we && (s2.rd == s1.rd);
  assign slot2_issue  = slot1_issue && s2_src_ok && !raw && !waw &&
                        !(s1.is_lsu && s2.is_lsu) && !s1.is_br;
  assign set2         = slot2_issue && s2.rd_we;
  assign set_addr2    = s2.rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1_q <= 1'b0;
      data2_q  <= '0;
    end else if (flush) begin
      valid1_q <= 1'b0;
    end else if (exe_ready) begin
      valid1_q <= slot2_issue;
      if (slot2_issue) data2_q <= fifo_data2;
    end
  end

  assign valid1      = valid1_q;
  assign issue_data2 = data2_q;
`else
  logic unused_lane1;

  assign s2_rj        = '0;
  assign s2_rk        = '0;
  assign slot2_issue  = 1'b0;
  assign set2         = 1'b0;
  assign set_addr2    = '0;
  assign valid1       = 1'b0;
  assign issue_data2  = '0;
  assign unused_lane1 = ^{fifo_data2, q_ready[3:2], s1.is_lsu, s1.is_br};
`endif

  assign invalid_en = slot2_issue ? PopTwo : (slot1_issue ? PopOne : PopNone);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid0_q <= 1'b0;
      data1_q  <= '0;
    end else if (flush) begin
      valid0_q <= 1'b0;
    end else if (exe_ready) begin
      valid0_q <= slot1_issue;
      if (slot1_issue) data1_q <= fifo_data1;
    end
  end

  assign issue_valid = {valid1, valid0_q};
  assign issue_data1 = data1_q;

endmodule
